// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM encoding, pc step/width, end marker and slot bundle.
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] PC_STEP    = 32'd4;
  localparam logic [31:0]     END_MARKER = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } slot_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_output_slot.sv
// One-entry valid/ready output register carrying instr and its pc.
// Ports: clk, reset, load/load_data, flush, ready in; valid, data out.
module fetch_output_slot
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  logic  ready,
  input  slot_t load_data,
  output logic  valid,
  output slot_t data
);

  logic  valid_d, valid_q;
  slot_t data_d, data_q;

  // flush beats load; a held word drains on ready
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns pc, FSM, fetch_count; feeds decode via slot.
// Ports: clk, reset, start, imem_*, branch_*, instr_*, halted, count.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [15:0]     cnt_d, cnt_q;

  logic  load, flush;
  logic  slot_free, is_end;
  slot_t load_data, slot_data;

  assign slot_free = !instr_valid || instr_ready;
  assign is_end    = HALT_ON_ZERO &&
                     (imem_data == END_MARKER);

  assign load_data.instr = imem_data;
  assign load_data.pc    = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH, ST_HALT: begin
        // redirect wins over capture and halt
        if (branch_valid) begin
          state_d = ST_FETCH;
          pc_d    = branch_target & ~32'd3;
          flush   = 1'b1;
        end else if (state_q == ST_FETCH &&
                     slot_free) begin
          if (is_end) begin
            state_d = ST_HALT;
          end else begin
            load  = 1'b1;
            pc_d  = pc_q + PC_STEP;
            cnt_d = sat_inc16(cnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_output_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .flush     (flush),
    .ready     (instr_ready),
    .load_data (load_data),
    .valid     (instr_valid),
    .data      (slot_data)
  );

  assign imem_addr   = pc_q;
  assign instr       = slot_data.instr;
  assign instr_pc    = slot_data.pc;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// Directed steps plus random traffic against a reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] imem_addr, imem_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [8] = '{
    32'hE2099F00, 32'hE3811F63, 32'hE0812001, 32'hE2522001,
    32'hE1A03002, 32'hE0834003, 32'hE3550000, 32'hE12FFF1E
  };

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd32) return prog[a[4:2]];
    return 32'd0;
  endfunction

  assign imem_data = mem_word(imem_addr);

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // reference model: running/stopped flags, pc, held word
  bit          m_started, m_halted, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc;
  int          m_cnt;

  task automatic model_step();
    logic [31:0] w;
    bit taken;
    if (reset) begin
      m_started = 0; m_halted = 0; m_valid = 0;
      m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    end else if (!m_started) begin
      if (start) m_started = 1;
    end else if (branch_valid) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_valid = 0;
      m_halted = 0;
    end else begin
      taken = m_valid && instr_ready;
      if (m_halted || (m_valid && !instr_ready)) begin
        if (taken) m_valid = 0;
      end else begin
        w = mem_word(m_pc);
        if (w == 0) begin
          m_halted = 1;
          if (taken) m_valid = 0;
        end else begin
          m_instr = w; m_ipc = m_pc; m_valid = 1;
          m_pc = m_pc + 4;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("addr", imem_addr, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("count", {16'd0, fetch_count}, m_cnt);
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; branch_valid = 0;
    branch_target = 0; instr_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    m_started = 0; m_halted = 0; m_valid = 0;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;

    // reset state
    do_reset();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_count", {16'd0, fetch_count}, 32'd0);

    // IDLE ignores branch
    branch_valid = 1; branch_target = 32'd12;
    cyc();
    branch_valid = 0;
    chk("idle_br_addr", imem_addr, 32'd0);

    // full program run, ready held high
    start = 1;
    cyc();
    start = 0;
    chk("start_nvalid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("seq_instr", instr, prog[i]);
      chk("seq_pc", instr_pc, 32'(i * 4));
    end
    cyc();
    chk("end_halted", {31'd0, halted}, 32'd1);
    chk("end_count", {16'd0, fetch_count}, 32'd8);
    chk("end_addr", imem_addr, 32'd32);

    // HALT then branch to 0 resumes fetch
    branch_valid = 1; branch_target = 32'd0;
    cyc();
    branch_valid = 0;
    chk("hbr_halted", {31'd0, halted}, 32'd0);
    chk("hbr_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    chk("hbr_instr", instr, 32'hE2099F00);

    // stall: ready low after first capture
    do_reset();
    start = 1;
    cyc();
    start = 0; instr_ready = 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stl_instr", instr, 32'hE2099F00);
      chk("stl_pc", instr_pc, 32'd0);
      chk("stl_addr", imem_addr, 32'd4);
      chk("stl_count", {16'd0, fetch_count}, 32'd1);
    end

    // reset during stalled transfer
    reset = 1;
    cyc();
    reset = 0;
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    chk("mrst_count", {16'd0, fetch_count}, 32'd0);
    instr_ready = 1;
    cyc();
    chk("mrst_idle", {31'd0, instr_valid}, 32'd0);

    // branch flushes held pc 8 word
    start = 1;
    cyc();
    start = 0;
    cyc(); cyc(); cyc();
    chk("br_held", instr_pc, 32'd8);
    branch_valid = 1; branch_target = 32'd17;
    cyc();
    branch_valid = 0;
    chk("br_flush", {31'd0, instr_valid}, 32'd0);
    chk("br_addr", imem_addr, 32'd16);
    cyc();
    chk("br_ipc", instr_pc, 32'd16);

    // branch in the same cycle as zero-word halt
    do_reset();
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 8; i++) cyc();
    chk("bh_pre_addr", imem_addr, 32'd32);
    chk("bh_pre_halt", {31'd0, halted}, 32'd0);
    branch_valid = 1; branch_target = 32'd4;
    cyc();
    branch_valid = 0;
    chk("bh_halted", {31'd0, halted}, 32'd0);
    chk("bh_addr", imem_addr, 32'd4);
    cyc();
    chk("bh_instr", instr, 32'hE3811F63);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      branch_valid = ($urandom_range(0, 11) == 0);
      branch_target = $urandom_range(0, 47);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential front end that reads the combinational instruction memory: it owns the program counter, presents a byte address each cycle, and captures the returned 32-bit word into a one-entry output register. Downstream decode consumes it through a valid/ready handshake. The unit supports start, branch redirect, stall under back-pressure and halting on the all-zero word the memory returns beyond the loaded program. It sits between the instruction memory and the decode/execute stage of the calculator core.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset (bits [1:0] must be 0)
- HALT_ON_ZERO, 1, when 1 an all-zero fetched word ends the program

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, leaves IDLE and begins fetching
- imem_addr  out  32  byte address to instruction memory, always equals pc
- imem_data  in  32  word returned combinationally by instruction memory
- branch_valid  in  1  redirect request, one cycle
- branch_target  in  32  redirect byte address; bits [1:0] ignored (forced 0)
- instr_valid  out  1  output register holds an instruction
- instr_ready  in  1  consumer accepts instruction this cycle
- instr  out  32  captured instruction word
- instr_pc  out  32  byte address the held instruction came from
- halted  out  1  unit is in HALT
- fetch_count  out  16  instructions captured since reset, saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, HALT.
- Reset: state IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_count=0; imem_addr therefore RESET_PC.
- IDLE: start -> FETCH. branch_valid ignored. No capture.
- Slot free = !instr_valid || instr_ready.
- FETCH, slot free, imem_data != 0 (or HALT_ON_ZERO=0): instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, fetch_count+=1 (saturating).
- FETCH, slot free, imem_data == 0 and HALT_ON_ZERO=1: -> HALT, halted<=1, pc unchanged, nothing captured; instr_valid<=0 if the held word was consumed this cycle.
- FETCH, slot not free: pc and output register hold (stall).
- HALT: no capture; a word still held stays valid until accepted; halted stays 1.
- branch_valid in FETCH or HALT: pc<={branch_target[31:2],2'b00}, instr_valid<=0 (held word flushed even if instr_ready), state FETCH, halted<=0. Branch wins over capture and halt in the same cycle.
- start while not in IDLE: ignored.
- pc wrap: 32'hFFFF_FFFC + 4 = 0, no flag.
- reset mid-operation overrides everything, including branch and a pending handshake.

## Timing
- Memory is combinational: word sampled in the same cycle imem_addr is presented.
- start at edge N -> FETCH from N; first instr_valid=1 after edge N+1.
- Sustained throughput one instruction per cycle while instr_ready=1.
- Branch at edge N -> imem_addr=target after N; target's instruction valid after N+1 (one bubble).
- Transfer occurs on a rising edge where instr_valid && instr_ready.
- instr and instr_pc stable while instr_valid=1 && instr_ready=0.

## Structure
- Package fetch_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, HALT=2'd2), PC_STEP=32'd4, END_MARKER=32'd0, PC width.
- One sub-module, fetch_output_slot: one-entry valid/ready register (load, flush, hold), carrying instr and instr_pc.
- Top holds the FSM, pc register and fetch_count.

## Test plan
- Reset, start, instr_ready=1 against the 8-word program: instr sequence 32'hE2099F00 (pc 0), 32'hE3811F63 (pc 4), ... pc 28; at pc 32 word 0 -> halted=1, fetch_count=8.
- instr_ready held 0 for 3 cycles after first capture: instr=32'hE2099F00, instr_pc=0 stable, imem_addr=4 held, fetch_count=1.
- branch_valid with branch_target=32'd17 while word at pc 8 held and instr_ready=1: held word flushed, imem_addr=16, next instr_pc=16, no transfer of pc 8.
- In HALT, branch_target=32'd0: halted=0, fetch resumes, next instr=32'hE2099F00.
- branch_valid and zero-word halt same cycle: state FETCH, halted=0, pc=target.
- reset asserted during stalled transfer: next cycle instr_valid=0, imem_addr=RESET_PC, state IDLE, fetch_count=0.
